ysyx_24070014_ifu: RTL and testbench
====================================

YSYX_24070014_IFU -- requirements
Module: ysyx_24070014_ifu

Interface
REQ-001 The block SHALL have parameter INIT_PC, default 32'h8000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter ADDR_LEN, default 32, giving the PC/address width; the instruction width is fixed at 32.
REQ-003 Port clk  in  1  clock; all state updates occur on the rising edge.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Port araddr  out  ADDR_LEN  fetch address, driven from the PC register.
REQ-006 Port arvalid  out  1  fetch request valid.
REQ-007 Port arready  in  1  memory accepts the request.
REQ-008 Port rdata  in  32  returned instruction word.
REQ-009 Port rresp  in  2  response status; 2'b00 means OK.
REQ-010 Port rvalid  in  1  response valid.
REQ-011 Port rready  out  1  IFU accepts the response.
REQ-012 Port out_valid  out  1  instruction available to the decoder.
REQ-013 Port out_ready  in  1  decoder accepts the instruction.
REQ-014 Port out_pc  out  ADDR_LEN  PC of the delivered instruction.
REQ-015 Port out_inst  out  32  delivered instruction.
REQ-016 Port out_fault  out  1  access fault: rresp was non-zero.
REQ-017 Port out_misalign  out  1  PC misaligned (see Configuration).
REQ-018 Port upd_valid  in  1  the execute/writeback stage presents the next PC.
REQ-019 Port upd_pc  in  ADDR_LEN  next PC: PC+4 or branch/jump target.
REQ-020 Port upd_ready  out  1  IFU accepts the next PC.

Function
REQ-021 The FSM SHALL have four states: FETCH, RESP, ISSUE and EXEC.
- FETCH: arvalid=1 only.
- RESP: rready=1 only.
- ISSUE: out_valid=1 only.
- EXEC: upd_ready=1 only.
REQ-022 Transitions SHALL be:
- FETCH->RESP on arvalid&arready.
- RESP->ISSUE on rvalid&rready.
- ISSUE->EXEC on out_valid&out_ready.
- EXEC->FETCH on upd_valid&upd_ready.
- Otherwise the FSM holds its state.
REQ-023 araddr SHALL equal the PC register in all states and SHALL remain stable while arvalid=1 and arready=0.
REQ-024 On the RESP handshake, rdata SHALL be captured into out_inst, and out_fault SHALL be set to (rresp!=0).
REQ-025 On an access fault, out_inst SHALL be 32'h0000_0000, and the instruction SHALL still be delivered through ISSUE.
REQ-026 out_pc, out_inst, out_fault and out_misalign SHALL remain stable from entry into ISSUE until the EXEC->FETCH transition.
REQ-027 On the EXEC handshake, the PC SHALL load upd_pc; no PC arithmetic is performed in this block.
REQ-028 With arready, rvalid, out_ready and upd_valid tied high, the minimum loop SHALL be 4 cycles per instruction, one per state.
REQ-029 Inputs arriving outside their owning state SHALL be ignored:
- rvalid outside RESP.
- out_ready outside ISSUE.
- upd_valid outside EXEC.
REQ-030 At most one fetch SHALL be outstanding; no new arvalid is raised before the previous response is consumed.
REQ-031 The PC SHALL wrap modulo 2^ADDR_LEN; upd_pc is taken verbatim.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL set:
- state to FETCH;
- PC to INIT_PC;
- out_inst, out_pc, out_fault and out_misalign to 0;
- arvalid, rready, out_valid and upd_ready to 0 in the cycle following that edge only if reset is still high, and FETCH outputs otherwise.
REQ-033 Reset SHALL override any in-flight handshake in any state; a response pending at reset is dropped, and system reset SHALL also reset the memory.
REQ-034 arvalid SHALL be 0 while reset is asserted and SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-035 Macro YSYX_24070014_IFU_MISALIGN_CHK_EN SHALL control the misalignment check.
REQ-036 With the macro defined, when PC[1:0]!=0 in FETCH, the block SHALL:
- not raise arvalid;
- go directly to ISSUE on the next edge;
- set out_misalign=1, out_inst=0 and out_fault=0.
REQ-037 Without the macro, out_misalign SHALL be tied to 0, and misaligned PCs SHALL be fetched like any other PC.

Verification
REQ-038 Reset release, with the memory returning 32'h0010_0093 and all ready/valid inputs high -> first arvalid with araddr=32'h8000_0000, then out_valid with out_inst=32'h0010_0093 on the third cycle after reset release, out_fault=0.
REQ-039 upd_pc=32'h8000_0010 in EXEC -> the next araddr is 32'h8000_0010; a 3-cycle arready stall holds araddr and arvalid stable.
REQ-040 rresp=2'b10 -> out_fault=1, out_inst=0, and the block proceeds to EXEC normally.
REQ-041 out_ready held low for 5 cycles -> out_valid, out_pc and out_inst stable; upd_valid pulsed during ISSUE is ignored and the PC is unchanged.
REQ-042 Reset asserted in RESP -> state FETCH and PC 32'h8000_0000 the next cycle; a late rvalid is not captured.
REQ-043 With the macro defined, upd_pc=32'h8000_0002 -> no arvalid, out_misalign=1; with the macro undefined -> a normal fetch at 32'h8000_0002.

Source files
------------

// File: rtl/ysyx_24070014_ifu.sv
// Instruction fetch unit: a four-state FETCH/RESP/ISSUE/EXEC loop with one outstanding read.
// Define YSYX_24070014_IFU_MISALIGN_CHK_EN to skip fetches of misaligned PCs and flag them instead.
module ysyx_24070014_ifu #(
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] INIT_PC  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_LEN-1:0] araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_LEN-1:0] out_pc,
    output logic [31:0]         out_inst,
    output logic                out_fault,
    output logic                out_misalign,
    input  logic                upd_valid,
    input  logic [ADDR_LEN-1:0] upd_pc,
    output logic                upd_ready
);

    typedef enum logic [1:0] {
        FETCH,
        RESP,
        ISSUE,
        EXEC
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_LEN-1:0] pc;
    logic                pc_misaligned;
    logic                resp_hs;
    logic                exec_hs;
    logic                skip_fetch;

`ifdef YSYX_24070014_IFU_MISALIGN_CHK_EN
    logic misalign_q;
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign out_misalign  = misalign_q;
`else
    assign pc_misaligned = 1'b0;
    assign out_misalign  = 1'b0;
`endif

    assign araddr = pc;

    // NOTE: every output and next_state gets a default before the case, so no path leaves a latch.
    always_comb begin
        next_state = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        out_valid  = 1'b0;
        upd_ready  = 1'b0;
        resp_hs    = 1'b0;
        exec_hs    = 1'b0;
        skip_fetch = 1'b0;
        case (state)
            FETCH: begin
                if (pc_misaligned) begin
                    skip_fetch = 1'b1;
                    next_state = ISSUE;
                end else begin
                    // Request is held off during reset so nothing is issued before the PC is valid.
                    arvalid = !reset;
                    if (arvalid && arready) next_state = RESP;
                end
            end
            RESP: begin
                rready  = 1'b1;
                resp_hs = rvalid;
                if (resp_hs) next_state = ISSUE;
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = EXEC;
            end
            EXEC: begin
                upd_ready = 1'b1;
                exec_hs   = upd_valid;
                if (exec_hs) next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= INIT_PC;
            out_pc    <= '0;
            out_inst  <= '0;
            out_fault <= 1'b0;
        end else begin
            state <= next_state;
            if (resp_hs) begin
                out_pc    <= pc;
                out_inst  <= (rresp == 2'b00) ? rdata : 32'h0000_0000;
                out_fault <= (rresp != 2'b00);
            end else if (skip_fetch) begin
                out_pc    <= pc;
                out_inst  <= 32'h0000_0000;
                out_fault <= 1'b0;
            end
            if (exec_hs) pc <= upd_pc;
        end
    end

`ifdef YSYX_24070014_IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset)           misalign_q <= 1'b0;
        else if (resp_hs)    misalign_q <= 1'b0;
        else if (skip_fetch) misalign_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ysyx_24070014_ifu.sv
// Bench for ysyx_24070014_ifu: directed reset/stall/fault/misalign scenarios, then randomized
// handshakes checked against a transaction-level scoreboard.
module tb_ysyx_24070014_ifu;

    localparam logic [31:0] INIT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        out_misalign;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_ready;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24070014_ifu #(
        .ADDR_LEN(32),
        .INIT_PC (INIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_fault   (out_fault),
        .out_misalign(out_misalign),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_ready   (upd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Scoreboard state for the random phase.
    logic [31:0] exp_pc;
    logic [31:0] fetched_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
    int          n_fetch, n_resp, n_deliv, n_retire;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        arready   = 1'b1;
        rvalid    = 1'b1;
        out_ready = 1'b1;
        upd_valid = 1'b1;
        rdata     = 32'h0010_0093;
        rresp     = 2'b00;
        upd_pc    = 32'h8000_0010;

        // Reset state.
        tick();
        tick();
        settle();
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_araddr", araddr, INIT);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_fault", out_fault, 0);
        check("rst_misalign", out_misalign, 0);

        // First instruction after release: FETCH, RESP, then ISSUE on the third cycle.
        reset = 1'b0;
        #1;
        check("c1_arvalid", arvalid, 1);
        check("c1_araddr", araddr, INIT);
        tick(); settle();
        check("c2_rready", rready, 1);
        check("c2_arvalid", arvalid, 0);
        tick(); settle();
        check("c3_out_valid", out_valid, 1);
        check("c3_out_inst", out_inst, 32'h0010_0093);
        check("c3_out_pc", out_pc, INIT);
        check("c3_out_fault", out_fault, 0);
        arready = 1'b0;
        tick(); settle();
        check("c4_upd_ready", upd_ready, 1);
        check("c4_araddr", araddr, INIT);

        // Redirect to 0x8000_0010 with a 3-cycle arready stall.
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, 32'h8000_0010);
            tick();
        end
        settle();
        arready   = 1'b1;
        rresp     = 2'b10;
        rdata     = 32'hdead_beef;
        out_ready = 1'b0;
        upd_pc    = 32'h1234_5678;
        tick();
        tick();

        // Faulted instruction held in ISSUE for 5 cycles while upd_valid is high.
        for (int i = 0; i < 5; i++) begin
            settle();
            check("hold_out_valid", out_valid, 1);
            check("hold_upd_ready", upd_ready, 0);
            check("hold_out_pc", out_pc, 32'h8000_0010);
            check("hold_out_inst", out_inst, 0);
            check("hold_out_fault", out_fault, 1);
            check("hold_araddr", araddr, 32'h8000_0010);
            tick();
        end
        out_ready = 1'b1;
        upd_pc    = 32'h8000_0020;
        rresp     = 2'b00;
        tick(); settle();
        check("fault_exec_upd_ready", upd_ready, 1);
        check("fault_exec_pc", araddr, 32'h8000_0010);
        check("fault_exec_out_fault", out_fault, 1);
        tick(); settle();
        check("next_arvalid", arvalid, 1);
        check("next_araddr", araddr, 32'h8000_0020);

        // Reset while a response is pending in RESP.
        tick();
        rvalid = 1'b0;
        reset  = 1'b1;
        settle();
        check("resp_rready", rready, 1);
        tick(); settle();
        check("rst_resp_araddr", araddr, INIT);
        check("rst_resp_arvalid", arvalid, 0);
        check("rst_resp_rready", rready, 0);
        check("rst_resp_out_valid", out_valid, 0);
        check("rst_resp_out_inst", out_inst, 0);
        reset   = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hcafe_f00d;
        #1;
        check("late_arvalid", arvalid, 1);
        tick(); settle();
        check("late_rready", rready, 0);
        check("late_out_inst", out_inst, 0);
        check("late_arvalid2", arvalid, 1);

        // Misaligned next PC.
        arready = 1'b1;
        rdata   = 32'h0000_0013;
        upd_pc  = 32'h8000_0002;
        tick(); tick(); tick(); tick();
        settle();
`ifdef YSYX_24070014_IFU_MISALIGN_CHK_EN
        check("mis_arvalid", arvalid, 0);
        tick(); settle();
        check("mis_out_valid", out_valid, 1);
        check("mis_flag", out_misalign, 1);
        check("mis_out_inst", out_inst, 0);
        check("mis_out_fault", out_fault, 0);
        check("mis_out_pc", out_pc, 32'h8000_0002);
`else
        check("mis_arvalid", arvalid, 1);
        check("mis_araddr", araddr, 32'h8000_0002);
        check("mis_flag", out_misalign, 0);
        tick(); tick(); settle();
        check("mis_out_valid", out_valid, 1);
        check("mis_out_pc", out_pc, 32'h8000_0002);
        check("mis_out_inst", out_inst, 32'h0000_0013);
        check("mis_flag_issue", out_misalign, 0);
`endif

        // Randomized handshakes against the transaction scoreboard.
        reset = 1'b1;
        tick(); tick();
        reset      = 1'b0;
        exp_pc     = INIT;
        fetched_pc = 32'h0;
        exp_inst   = 32'h0;
        exp_fault  = 1'b0;
        n_fetch    = 0;
        n_resp     = 0;
        n_deliv    = 0;
        n_retire   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            arready   = $urandom_range(0, 1) == 1;
            rvalid    = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            upd_valid = $urandom_range(0, 1) == 1;
            rdata     = $urandom;
            rresp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            upd_pc    = $urandom & 32'hffff_fffc;
            settle();
            check("one_active", 32'(arvalid) + 32'(rready) + 32'(out_valid) + 32'(upd_ready), 1);
            if (arvalid) begin
                check("rnd_araddr", araddr, exp_pc);
                check("rnd_prev_retired", n_fetch, n_retire);
                if (arready) begin
                    fetched_pc = exp_pc;
                    n_fetch++;
                end
            end
            if (rready) begin
                check("rnd_resp_order", n_resp + 1, n_fetch);
                if (rvalid) begin
                    exp_inst  = (rresp == 2'b00) ? rdata : 32'h0;
                    exp_fault = (rresp != 2'b00);
                    n_resp++;
                end
            end
            if (out_valid) begin
                check("rnd_deliv_order", n_deliv + 1, n_resp);
                check("rnd_out_pc", out_pc, fetched_pc);
                check("rnd_out_inst", out_inst, exp_inst);
                check("rnd_out_fault", out_fault, exp_fault);
                if (out_ready) n_deliv++;
            end
            if (upd_ready) begin
                check("rnd_retire_order", n_retire + 1, n_deliv);
                check("rnd_exec_pc", araddr, exp_pc);
                check("rnd_exec_out_pc", out_pc, fetched_pc);
                if (upd_valid) begin
                    exp_pc = upd_pc;
                    n_retire++;
                end
            end
            tick();
        end
        check("rnd_progress", 32'(n_retire > 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
